// File: rtl/core_task_dispatch_pkg.sv
// Shared chronos types: task payload, CQ slot, thread ids and per-thread dispatch state.
// Pure declarations; no logic, no latency.
package chronos;

    localparam int N_THREADS = 4;
    localparam int THR_W     = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
    localparam int CQ_SLOT_W = 6;

    typedef logic [THR_W-1:0]     thread_id_t;
    typedef logic [CQ_SLOT_W-1:0] cq_slice_slot_t;

    typedef struct packed {
        logic [31:0] ts;
        logic [7:0]  fn;
        logic [31:0] arg;
    } task_t;

    typedef enum logic [1:0] {
        THR_IDLE    = 2'd0,
        THR_LOADED  = 2'd1,
        THR_RUNNING = 2'd2,
        THR_DONE    = 2'd3
    } thread_state_t;

endpackage

// File: rtl/core_task_dispatch_rr_select.sv
// Round-robin pick among requesters starting at ptr; purely combinational.
// Zero latency; no backpressure (any=0 when nothing requests).
module rr_select #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt,
    output logic          any
);

    always_comb begin : sel
        int idx;
        idx = 0;
        gnt = '0;
        any = |req;
        // Scan farthest-first so the requester closest to ptr is the last writer.
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/core_task_dispatch.sv
// Per-thread task dispatch: hold issued tasks, track thread progress, finish DONE threads to the CQ.
// Accept is 1 cycle to thr_valid; unlock/finish_task 1 cycle after fin handshake; s_ready per thread, fin held until fin_ready.
module core_task_dispatch
    import chronos::*;
#(
    parameter int TILE_ID = 0,
    parameter int N_THR   = N_THREADS
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  task_t                   s_rdata,
    input  cq_slice_slot_t          s_cq_slot,
    input  thread_id_t              s_thread,
    output logic [N_THR-1:0]        thr_valid,
    output task_t [N_THR-1:0]       thr_task,
    input  logic [N_THR-1:0]        thr_ack,
    input  logic [N_THR-1:0]        thr_done,
    output logic                    fin_valid,
    input  logic                    fin_ready,
    output cq_slice_slot_t          fin_cq_slot,
    output logic                    unlock_valid,
    output thread_id_t              unlock_thread,
    output logic                    finish_task,
    output logic [$clog2(N_THR):0]  n_busy,
    output logic                    err
);

    localparam int BUSY_W = $clog2(N_THR) + 1;

    if (N_THR < 1 || N_THR > N_THREADS || TILE_ID < 0) begin : g_bad_cfg
        $error("core_task_dispatch: unsupported N_THR/TILE_ID");
    end

    thread_state_t  state     [N_THR];
    task_t          slot_task [N_THR];
    cq_slice_slot_t slot_cq   [N_THR];

    thread_id_t       rr_ptr;
    thread_id_t       rr_gnt;
    thread_id_t       gnt_q;
    thread_id_t       fin_gnt;
    thread_id_t       next_ptr;
    logic             gnt_held;
    logic             rr_any;
    logic [N_THR-1:0] done_vec;
    logic             s_in_range;
    logic             accept;
    logic             fin_hs;
    logic             proto_err;

    if (N_THR == (1 << THR_W)) begin : g_full_range
        assign s_in_range = 1'b1;
    end else begin : g_part_range
        assign s_in_range = (s_thread < thread_id_t'(N_THR));
    end

    assign s_ready = s_in_range && (state[s_thread] == THR_IDLE);
    assign accept  = s_valid && s_ready;

    always_comb begin
        done_vec  = '0;
        thr_valid = '0;
        for (int i = 0; i < N_THR; i++) begin
            done_vec[i]  = (state[i] == THR_DONE);
            thr_valid[i] = (state[i] == THR_LOADED);
            thr_task[i]  = slot_task[i];
        end
    end

    rr_select #(
        .N  (N_THR),
        .IW (THR_W)
    ) u_rr_select (
        .req (done_vec),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .any (rr_any)
    );

    // Once offered, the grant is frozen so the CQ sees a stable slot while stalled.
    assign fin_gnt     = gnt_held ? gnt_q : rr_gnt;
    assign fin_valid   = gnt_held || rr_any;
    assign fin_cq_slot = slot_cq[fin_gnt];
    assign fin_hs      = fin_valid && fin_ready;
    assign next_ptr    = (fin_gnt == thread_id_t'(N_THR - 1)) ? '0 : fin_gnt + thread_id_t'(1);

    always_comb begin
        proto_err = s_valid && !s_ready;
        for (int i = 0; i < N_THR; i++) begin
            if (thr_ack[i] && state[i] != THR_LOADED) begin
                proto_err = 1'b1;
            end
            if (thr_done[i] && state[i] != THR_LOADED && state[i] != THR_RUNNING) begin
                proto_err = 1'b1;
            end
        end
    end

    always_comb begin
        n_busy = '0;
        for (int i = 0; i < N_THR; i++) begin
            if (state[i] != THR_IDLE) begin
                n_busy = n_busy + BUSY_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_THR; i++) begin
                state[i] <= THR_IDLE;
            end
            rr_ptr        <= '0;
            gnt_q         <= '0;
            gnt_held      <= 1'b0;
            unlock_valid  <= 1'b0;
            unlock_thread <= '0;
            finish_task   <= 1'b0;
            err           <= 1'b0;
        end else begin
            unlock_valid <= fin_hs;
            finish_task  <= fin_hs;
            if (fin_hs) begin
                unlock_thread <= fin_gnt;
                rr_ptr        <= next_ptr;
                gnt_held      <= 1'b0;
            end else if (fin_valid && !gnt_held) begin
                gnt_held <= 1'b1;
                gnt_q    <= rr_gnt;
            end

            for (int i = 0; i < N_THR; i++) begin
                case (state[i])
                    THR_IDLE: begin
                        if (accept && s_thread == thread_id_t'(i)) begin
                            state[i] <= THR_LOADED;
                        end
                    end
                    THR_LOADED: begin
                        if (thr_ack[i]) begin
                            state[i] <= thr_done[i] ? THR_DONE : THR_RUNNING;
                        end
                    end
                    THR_RUNNING: begin
                        if (thr_done[i]) begin
                            state[i] <= THR_DONE;
                        end
                    end
                    THR_DONE: begin
                        if (fin_hs && fin_gnt == thread_id_t'(i)) begin
                            state[i] <= THR_IDLE;
                        end
                    end
                    default: state[i] <= THR_IDLE;
                endcase
            end

            if (proto_err) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_task[s_thread] <= s_rdata;
            slot_cq[s_thread]   <= s_cq_slot;
        end
    end

endmodule

// File: tb/tb_core_task_dispatch.sv
// Directed scoreboard bench for core_task_dispatch (N_THR=4).
module tb_core_task_dispatch;
    import chronos::*;

    logic           clk = 1'b0;
    logic           rstn;
    logic           s_valid;
    logic           s_ready;
    task_t          s_rdata;
    cq_slice_slot_t s_cq_slot;
    thread_id_t     s_thread;
    logic [3:0]     thr_valid;
    task_t [3:0]    thr_task;
    logic [3:0]     thr_ack;
    logic [3:0]     thr_done;
    logic           fin_valid;
    logic           fin_ready;
    cq_slice_slot_t fin_cq_slot;
    logic           unlock_valid;
    thread_id_t     unlock_thread;
    logic           finish_task;
    logic [2:0]     n_busy;
    logic           err;

    core_task_dispatch #(.TILE_ID(0), .N_THR(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_rdata       (s_rdata),
        .s_cq_slot     (s_cq_slot),
        .s_thread      (s_thread),
        .thr_valid     (thr_valid),
        .thr_task      (thr_task),
        .thr_ack       (thr_ack),
        .thr_done      (thr_done),
        .fin_valid     (fin_valid),
        .fin_ready     (fin_ready),
        .fin_cq_slot   (fin_cq_slot),
        .unlock_valid  (unlock_valid),
        .unlock_thread (unlock_thread),
        .finish_task   (finish_task),
        .n_busy        (n_busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int thr;
        int slot;
    } exp_t;

    exp_t exp_q[$];
    int   unl_cyc[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    bit   hs_prev = 1'b0;
    int   exp_unl_thr = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic task_t mk(input int n);
        task_t t;
        t.ts  = 32'h1000_0000 + n;
        t.fn  = 8'(n * 3);
        t.arg = ~(32'h00ab_0000 + n);
        return t;
    endfunction

    function automatic exp_t ex(input int t, input int s);
        exp_t e;
        e.thr  = t;
        e.slot = s;
        return e;
    endfunction

    // Scoreboard monitor: pops at every fin handshake, checks the unlock pulse one cycle later.
    always @(negedge clk) begin
        if (!rstn) begin
            hs_prev = 1'b0;
        end else begin
            if (hs_prev || unlock_valid) begin
                check("unlock_valid_timing", unlock_valid, hs_prev);
                check("finish_task_timing", finish_task, hs_prev);
                if (hs_prev) check("unlock_thread", unlock_thread, exp_unl_thr);
                if (unlock_valid) unl_cyc.push_back(cyc);
            end
            hs_prev = 1'b0;
            if (fin_valid && fin_ready) begin
                if (exp_q.size() == 0) begin
                    check("fin_unexpected", 1, 0);
                    exp_unl_thr = -1;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("fin_cq_slot", fin_cq_slot, e.slot);
                    exp_unl_thr = e.thr;
                end
                hs_prev = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int t, input int slot);
        s_valid   = 1'b1;
        s_thread  = thread_id_t'(t);
        s_rdata   = mk(slot);
        s_cq_slot = cq_slice_slot_t'(slot);
        @(negedge clk);
        check("s_ready_on_issue", s_ready, 1);
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rstn      = 1'b0;
        s_valid   = 1'b0;
        s_rdata   = '0;
        s_cq_slot = '0;
        s_thread  = '0;
        thr_ack   = '0;
        thr_done  = '0;
        fin_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_thr_valid", thr_valid, 0);
        check("rst_fin_valid", fin_valid, 0);
        check("rst_unlock_valid", unlock_valid, 0);
        check("rst_finish_task", finish_task, 0);
        check("rst_n_busy", n_busy, 0);
        check("rst_err", err, 0);
        tick();
        rstn      = 1'b1;
        fin_ready = 1'b1;
        tick();

        // Single task on thread 2, ack then done three cycles later.
        @(negedge clk);
        check("a_n_busy_idle", n_busy, 0);
        tick();
        exp_q.push_back(ex(2, 5));
        issue(2, 5);
        thr_ack = 4'b0100;
        @(negedge clk);
        check("a_thr_valid", thr_valid, 4'b0100);
        check("a_thr_task", thr_task[2], mk(5));
        check("a_n_busy_loaded", n_busy, 1);
        tick();
        thr_ack = '0;
        tick();
        tick();
        thr_done = 4'b0100;
        @(negedge clk);
        check("a_n_busy_running", n_busy, 1);
        tick();
        thr_done = '0;
        tick();
        @(negedge clk);
        check("a_n_busy_after", n_busy, 0);
        tick();

        // Ack and done together on thread 0: straight to DONE, one finish only.
        exp_q.push_back(ex(0, 9));
        issue(0, 9);
        thr_ack  = 4'b0001;
        thr_done = 4'b0001;
        tick();
        thr_ack  = '0;
        thr_done = '0;
        @(negedge clk);
        check("b_err_clean", err, 0);
        repeat (4) tick();

        // Three threads done at once with rr_ptr=1: finish order 1,3,0.
        issue(0, 10);
        issue(1, 11);
        issue(3, 13);
        exp_q.push_back(ex(1, 11));
        exp_q.push_back(ex(3, 13));
        exp_q.push_back(ex(0, 10));
        thr_ack = 4'b1011;
        @(negedge clk);
        check("c_thr_valid", thr_valid, 4'b1011);
        check("c_n_busy", n_busy, 3);
        tick();
        thr_ack  = '0;
        thr_done = 4'b1011;
        tick();
        thr_done = '0;
        repeat (5) tick();
        if (unl_cyc.size() >= 3) begin
            check("c_unlock_gap_a", unl_cyc[unl_cyc.size()-1] - unl_cyc[unl_cyc.size()-2], 1);
            check("c_unlock_gap_b", unl_cyc[unl_cyc.size()-2] - unl_cyc[unl_cyc.size()-3], 1);
        end else begin
            check("c_unlock_count", unl_cyc.size(), 3);
        end

        // Finish on thread 2 moves rr_ptr to 3, so thread 0 would outrank thread 1.
        exp_q.push_back(ex(2, 22));
        issue(2, 22);
        thr_ack  = 4'b0100;
        thr_done = 4'b0100;
        tick();
        thr_ack  = '0;
        thr_done = '0;
        repeat (3) tick();

        // Stalled CQ: grant latched on thread 1 even after thread 0 finishes.
        fin_ready = 1'b0;
        issue(1, 21);
        issue(0, 20);
        exp_q.push_back(ex(1, 21));
        exp_q.push_back(ex(0, 20));
        thr_ack  = 4'b0010;
        thr_done = 4'b0010;
        tick();
        thr_ack  = 4'b0001;
        thr_done = 4'b0001;
        tick();
        thr_ack  = '0;
        thr_done = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("d_fin_valid_hold", fin_valid, 1);
            check("d_fin_slot_hold", fin_cq_slot, 21);
            tick();
        end
        fin_ready = 1'b1;
        repeat (4) tick();

        // Issue to a LOADED thread: refused, payload kept, err sticky.
        exp_q.push_back(ex(3, 30));
        issue(3, 30);
        s_valid   = 1'b1;
        s_thread  = 2'd3;
        s_rdata   = mk(31);
        s_cq_slot = 6'd31;
        @(negedge clk);
        check("e_s_ready_busy", s_ready, 0);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check("e_err_set", err, 1);
        check("e_task_kept", thr_task[3], mk(30));
        check("e_still_loaded", thr_valid[3], 1);
        tick();
        thr_ack = 4'b1000;
        tick();
        thr_ack = '0;
        tick();
        thr_done = 4'b1000;
        tick();
        thr_done = '0;
        repeat (3) tick();
        @(negedge clk);
        check("e_err_sticky", err, 1);
        tick();

        // Async reset with work in flight and fin_valid pending.
        fin_ready = 1'b0;
        issue(0, 40);
        issue(1, 41);
        issue(2, 42);
        thr_ack  = 4'b0001;
        thr_done = 4'b0001;
        tick();
        thr_ack  = '0;
        thr_done = '0;
        @(negedge clk);
        check("f_fin_valid_pre", fin_valid, 1);
        check("f_n_busy_pre", n_busy, 3);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check("f_s_ready", s_ready, 1);
        check("f_thr_valid", thr_valid, 0);
        check("f_fin_valid", fin_valid, 0);
        check("f_unlock_valid", unlock_valid, 0);
        check("f_finish_task", finish_task, 0);
        check("f_n_busy", n_busy, 0);
        check("f_err", err, 0);
        fin_ready = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("f_n_busy_after", n_busy, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/core_task_dispatch.md
CORE_TASK_DISPATCH -- requirements
Module: core_task_dispatch

Interface
REQ-001 Parameter: TILE_ID, 0, tile index (stats/debug gating only).
REQ-002 Parameter: N_THR, N_THREADS (package), number of core threads served.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  task issued by serializer; s_rdata/s_cq_slot/s_thread valid.
REQ-006 s_ready  output  1  dispatcher accepts issued task.
REQ-007 s_rdata  input  task_t  issued task.
REQ-008 s_cq_slot  input  cq_slice_slot_t  CQ slot of issued task.
REQ-009 s_thread  input  thread_id_t  destination thread.
REQ-010 thr_valid  output  N_THR  per-thread task-present.
REQ-011 thr_task  output  N_THR x task_t  per-thread task payload.
REQ-012 thr_ack  input  N_THR  thread has taken its task.
REQ-013 thr_done  input  N_THR  thread finished its task (1-cycle pulse).
REQ-014 fin_valid  output  1  finish request to CQ.
REQ-015 fin_ready  input  1  CQ accepts finish.
REQ-016 fin_cq_slot  output  cq_slice_slot_t  slot being finished.
REQ-017 unlock_valid  output  1  thread released (to serializer).
REQ-018 unlock_thread  output  thread_id_t  released thread.
REQ-019 finish_task  output  1  running-task decrement pulse (to serializer).
REQ-020 n_busy  output  clog2(N_THR)+1  threads not IDLE.
REQ-021 err  output  1  sticky protocol-error flag.

Function
REQ-022 Each thread SHALL hold one FSM: IDLE -> LOADED -> RUNNING -> DONE -> IDLE.
REQ-023 s_ready SHALL be combinational: 1 iff state[s_thread]==IDLE.
REQ-024 On s_valid&s_ready: slot[s_thread] captures s_rdata and s_cq_slot; state -> LOADED next cycle.
REQ-025 thr_valid[i] SHALL be 1 iff state[i]==LOADED; thr_task[i] = slot task, stable while LOADED.
REQ-026 LOADED & thr_ack[i] -> RUNNING; if thr_done[i] in same cycle -> DONE directly.
REQ-027 RUNNING & thr_done[i] -> DONE.
REQ-028 thr_ack outside LOADED, thr_done outside LOADED/RUNNING, or s_valid with s_ready=0 SHALL be ignored for state and SHALL set err.
REQ-029 Finish arbitration: round-robin among DONE threads, starting at rr_ptr; 0 DONE -> fin_valid=0.
REQ-030 Grant SHALL be latched when fin_valid rises; grant, fin_cq_slot held until fin_valid&fin_ready.
REQ-031 On fin_valid&fin_ready: granted thread -> IDLE; rr_ptr <= grant+1 mod N_THR.
REQ-032 unlock_valid and finish_task SHALL be registered, high exactly one cycle after the fin handshake; unlock_thread = that grant.
REQ-033 At most one unlock per cycle; back-to-back finishes allowed (fin_valid may reassert the cycle after a handshake).
REQ-034 A thread released by unlock SHALL accept s_valid the cycle after fin handshake (IDLE at that edge).
REQ-035 n_busy SHALL be a count of non-IDLE threads, updated each cycle; never exceeds N_THR.
REQ-036 Throughput: one accept and one finish per cycle, independent of each other.

Reset
REQ-037 Asynchronous assertion of rstn SHALL force all states IDLE, rr_ptr=0, grant latch clear, err=0.
REQ-038 During/after reset: s_ready follows IDLE (1), thr_valid=0, fin_valid=0, unlock_valid=0, finish_task=0, n_busy=0; payload registers need no reset.
REQ-039 Reset mid-operation SHALL drop in-flight tasks without issuing unlock or finish.

Structure
REQ-040 thread_state_t (4-value enum) SHALL be added to package chronos; task_t, cq_slice_slot_t, thread_id_t, N_THREADS reused from it.
REQ-041 One sub-module, rr_select (N-bit request vector + pointer -> grant index + any), SHALL implement REQ-029.

Verification (N_THR=4)
REQ-042 s_thread=2 issue, thr_ack[2] next cycle, thr_done[2] 3 cycles later, fin_ready=1 -> fin_cq_slot = issued slot, unlock_valid pulse with unlock_thread=2 one cycle after handshake, n_busy 0->1->0.
REQ-043 thr_done on threads 0,1,3 same cycle, fin_ready=1, rr_ptr=1 -> unlocks in order 1,3,0 on 3 consecutive cycles.
REQ-044 fin_ready=0 for 5 cycles while thread 1 DONE, thread 0 becomes DONE meanwhile -> fin_cq_slot/grant remain thread 1 until handshake, then thread 0.
REQ-045 s_valid to thread 3 while LOADED -> s_ready=0, slot unchanged, err=1 sticky.
REQ-046 thr_ack and thr_done same cycle on thread 0 -> DONE next cycle, single finish issued.
REQ-047 rstn asserted with 3 threads busy and fin_valid=1 -> all outputs at reset values asynchronously, no unlock pulse, n_busy=0.
